// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, pixel/window types and the output saturation helper
// for the sobel_edge streaming edge-magnitude stage.
//   PIX_W   : grey pixel width
//   SUM_W   : width of |Gx|+|Gy| (max 32760)
//   PIX_MAX : largest representable output pixel
package sobel_pkg;

    localparam int unsigned PIX_W = 12;
    localparam int unsigned SUM_W = 15;
    localparam logic [PIX_W-1:0] PIX_MAX = 12'hFFF;

    typedef logic [PIX_W-1:0] pix_t;
    // win[row][col]: row 0 is the oldest line, col 2 the newest column
    typedef pix_t [2:0][2:0] win_t;

    // Clamp a 15-bit magnitude to the 12-bit pixel range
    function automatic pix_t sat12(input logic [SUM_W-1:0] mag);
        return (|mag[SUM_W-1:PIX_W]) ? PIX_MAX : mag[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two cascaded DEPTH-deep pixel shift registers, advanced only
// when iCLKEN is high. With DEPTH equal to the line width, the taps present the
// pixel in the same column one line (oTAP1) and two lines (oTAP2) above the pixel
// currently on iDATA. Contents are deliberately not reset.
//   iCLK   : pixel clock
//   iCLKEN : shift enable (input pixel valid)
//   iDATA  : incoming pixel
//   oTAP1  : same column, previous line
//   oTAP2  : same column, two lines back
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH = 640
) (
    input  logic iCLK,
    input  logic iCLKEN,
    input  pix_t iDATA,
    output pix_t oTAP1,
    output pix_t oTAP2
);

    pix_t line1 [DEPTH];
    pix_t line2 [DEPTH];

    always_ff @(posedge iCLK) begin
        if (iCLKEN) begin
            line1[0] <= iDATA;
            line2[0] <= line1[DEPTH-1];
            for (int i = 1; i < DEPTH; i++) begin
                line1[i] <= line1[i-1];
                line2[i] <= line2[i-1];
            end
        end
    end

    assign oTAP1 = line1[DEPTH-1];
    assign oTAP2 = line2[DEPTH-1];

endmodule

// File: rtl/sobel_edge.sv
// sobel_edge: streaming 3x3 Sobel edge magnitude, one output pixel per input pixel,
// fixed 3-cycle latency (oDVAL is iDVAL delayed by 3 clocks).
//   iCLK  : pixel clock          iRST  : asynchronous active-high reset
//   iDATA : grey pixel           iDVAL : input valid
//   iSOF  : start of frame (qualified by iDVAL), marks pixel (0,0)
//   oDATA : min(|Gx|+|Gy|, 4095), 0 for rows/cols 0..1
//   oDVAL : output valid
// Build option: define SOBEL_THRESH_EN to binarise the output against THRESH
// (4095 when mag >= THRESH, else 0); border pixels stay 0.
module sobel_edge
    import sobel_pkg::*;
#(
    parameter int unsigned       IMG_WIDTH = 640,
    parameter logic [PIX_W-1:0]  THRESH    = 12'd512
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [PIX_W-1:0] iDATA,
    input  logic             iDVAL,
    input  logic             iSOF,
    output logic [PIX_W-1:0] oDATA,
    output logic             oDVAL
);

    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W = 11;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = '1;

    // Column and row of the pixel currently presented on iDATA
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             border_d;

    pix_t tap1, tap2;
    win_t win_q;
    logic border0_q, vld0_q;

    logic [SUM_W-1:0] gx, gy, gx_abs, gy_abs;
    logic [SUM_W-1:0] abs_gx_q, abs_gy_q;
    logic             border1_q, vld1_q;

    logic [SUM_W-1:0] mag;
    pix_t             res;

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH)
    ) u_line_buffer (
        .iCLK   (iCLK),
        .iCLKEN (iDVAL),
        .iDATA  (iDATA),
        .oTAP1  (tap1),
        .oTAP2  (tap2)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (iSOF) begin
            col_d = COL_W'(1);
            row_d = '0;
        end else if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q != ROW_MAX) begin
                row_d = row_q + ROW_W'(1);
            end
        end else begin
            col_d = col_q + COL_W'(1);
        end
    end

    // An SOF pixel is (0,0) regardless of where the counters had got to
    assign border_d = iSOF | (row_q < ROW_W'(2)) | (col_q < COL_W'(2));

    // E0: counters, window and border flag
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '0;
            border0_q <= 1'b0;
            vld0_q    <= 1'b0;
        end else begin
            vld0_q <= iDVAL;
            if (iDVAL) begin
                col_q     <= col_d;
                row_q     <= row_d;
                border0_q <= border_d;
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= tap2;
                win_q[1][2] <= tap1;
                win_q[2][2] <= iDATA;
            end
        end
    end

    // a + 2b + c, at most 16380
    function automatic logic [SUM_W-2:0] wsum(input pix_t a, input pix_t b, input pix_t c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    always_comb begin
        gx = {1'b0, wsum(win_q[0][2], win_q[1][2], win_q[2][2])}
           - {1'b0, wsum(win_q[0][0], win_q[1][0], win_q[2][0])};
        gy = {1'b0, wsum(win_q[2][0], win_q[2][1], win_q[2][2])}
           - {1'b0, wsum(win_q[0][0], win_q[0][1], win_q[0][2])};
        gx_abs = gx[SUM_W-1] ? (~gx + SUM_W'(1)) : gx;
        gy_abs = gy[SUM_W-1] ? (~gy + SUM_W'(1)) : gy;
    end

    // E1: absolute gradients
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            abs_gx_q  <= '0;
            abs_gy_q  <= '0;
            border1_q <= 1'b0;
            vld1_q    <= 1'b0;
        end else begin
            abs_gx_q  <= gx_abs;
            abs_gy_q  <= gy_abs;
            border1_q <= border0_q;
            vld1_q    <= vld0_q;
        end
    end

    assign mag = abs_gx_q + abs_gy_q;

`ifdef SOBEL_THRESH_EN
    always_comb begin
        res = (mag >= {3'b000, THRESH}) ? PIX_MAX : '0;
        if (border1_q) begin
            res = '0;
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;

    always_comb begin
        res = sat12(mag);
        if (border1_q) begin
            res = '0;
        end
    end
`endif

    // E2: output register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDATA <= '0;
            oDVAL <= 1'b0;
        end else begin
            oDATA <= res;
            oDVAL <= vld1_q;
        end
    end

endmodule
